// File: rtl/branch_predictor_table_if.sv
// Decode-side prediction and resolve-side update signals of branch_predictor_table.
// The master drives the pipeline side; the slave is the predictor table.
interface branch_predictor_table_if #(
   parameter int INDEX_BITS = 6
);
   logic                  branch_decode_sig;
   logic [31:0]           in_addr;
   logic [31:0]           offset;
   logic [31:0]           branch_addr;
   logic                  prediction;
   logic [INDEX_BITS-1:0] pred_index;
   logic                  update_valid;
   logic [INDEX_BITS-1:0] update_index;
   logic                  actual_branch_decision;
   logic                  update_predicted;
   logic [15:0]           mispredict_count;

   modport master (
      output branch_decode_sig, in_addr, offset, update_valid, update_index,
             actual_branch_decision, update_predicted,
      input  branch_addr, prediction, pred_index, mispredict_count
   );

   modport slave (
      input  branch_decode_sig, in_addr, offset, update_valid, update_index,
             actual_branch_decision, update_predicted,
      output branch_addr, prediction, pred_index, mispredict_count
   );
endinterface

// File: rtl/branch_predictor_table.sv
// Table of saturating counters giving a zero-latency taken/not-taken prediction.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR the table index with a global history register.
module branch_predictor_table #(
   parameter int INDEX_BITS = 6,
   parameter int CTR_BITS   = 2,
   parameter int CTR_INIT   = 0
) (
   input logic                     clk,
   input logic                     reset,
   branch_predictor_table_if.slave bp
);
   localparam int                  DEPTH   = 1 << INDEX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};
   localparam logic [CTR_BITS-1:0] CTR_ONE = {{(CTR_BITS-1){1'b0}}, 1'b1};
   localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(CTR_INIT);

   logic [CTR_BITS-1:0]   table_r [DEPTH];
   logic [15:0]           mispredict_count_r;
   logic [INDEX_BITS-1:0] base_index_s;
   logic [INDEX_BITS-1:0] eff_index_s;

   function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] ctr,
                                                    input logic taken);
      logic [CTR_BITS-1:0] nxt;
      if (taken) begin
         nxt = (ctr == CTR_MAX) ? ctr : ctr + CTR_ONE;
      end else begin
         nxt = (ctr == CTR_MIN) ? ctr : ctr - CTR_ONE;
      end
      return nxt;
   endfunction

   assign base_index_s = bp.in_addr[INDEX_BITS+1:2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [INDEX_BITS-1:0] history_r;

   // Global history: newest resolved outcome enters at bit 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         history_r <= {INDEX_BITS{1'b0}};
      end else if (bp.update_valid) begin
         history_r <= {history_r[INDEX_BITS-2:0], bp.actual_branch_decision};
      end else begin
         history_r <= history_r;
      end
   end

   assign eff_index_s = base_index_s ^ history_r;
`else
   assign eff_index_s = base_index_s;
`endif

   // Predictions read the pre-edge table, so same-cycle updates are not forwarded.
   assign bp.branch_addr      = bp.in_addr + bp.offset;
   assign bp.pred_index       = eff_index_s;
   assign bp.prediction       = table_r[eff_index_s][CTR_BITS-1] & bp.branch_decode_sig;
   assign bp.mispredict_count = mispredict_count_r;

   // Counter table training; reset wins over a coincident update.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_r[i] <= CTR_RST;
         end
      end else if (bp.update_valid) begin
         table_r[bp.update_index] <= ctr_next(table_r[bp.update_index],
                                              bp.actual_branch_decision);
      end
   end

   // Saturating count of resolved mispredictions.
   always_ff @(posedge clk) begin
      if (reset) begin
         mispredict_count_r <= 16'h0000;
      end else if (bp.update_valid && (bp.update_predicted != bp.actual_branch_decision)
                   && (mispredict_count_r != 16'hFFFF)) begin
         mispredict_count_r <= mispredict_count_r + 16'h0001;
      end else begin
         mispredict_count_r <= mispredict_count_r;
      end
   end
endmodule
